// File: rtl/fifo_pop_pkg.sv
// Shared state encoding and default sizing for the FIFO pop arbiter.
package fifo_pop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int DEF_NUM_FIFOS   = 4;
  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_SRC_WIDTH   = 2;
  localparam int DEF_COUNT_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  input  logic                 en_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [IDX_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_vld_o
);

  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    if (en_i) begin
      // NUM_REQ is a power of two, so the IDX_WIDTH-bit add wraps for free.
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ptr_i + k[IDX_WIDTH-1:0];
        if (!gnt_vld_o && req_i[cand]) begin
          gnt_vld_o = 1'b1;
          gnt_idx_o = cand;
        end
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Drains a bank of FIFOs round-robin, one pop per cycle, and forwards each word
// with its source index two cycles after the pop; stalls new pops on almost-full.
module fifo_pop_arbiter
  import fifo_pop_pkg::*;
#(
  parameter int NUM_FIFOS   = DEF_NUM_FIFOS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SRC_WIDTH   = DEF_SRC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data,
  input  logic                            out_almost_full,
  output logic [NUM_FIFOS-1:0]            fifo_read,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SRC_WIDTH-1:0]            out_src,
  output logic                            idle,
  output logic [COUNT_WIDTH-1:0]          pop_count
);

  state_t                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   prio_q, prio_d;
  logic                   pend_q;
  logic [SRC_WIDTH-1:0]   gidx_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [SRC_WIDTH-1:0]   out_src_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  logic                   any_req;
  logic                   rd_en;
  logic [NUM_FIFOS-1:0]   gnt;
  logic [SRC_WIDTH-1:0]   gnt_idx;
  logic                   gnt_vld;
  logic [DATA_WIDTH-1:0]  word_sel;

  assign any_req = |(~fifo_empty);
  // Gating on the live stall input keeps the transition cycle read-free too.
  assign rd_en   = (state_q == ACTIVE) && !out_almost_full;

  rr_arbiter #(
    .NUM_REQ   (NUM_FIFOS),
    .IDX_WIDTH (SRC_WIDTH)
  ) u_rr_arbiter (
    .req_i     (~fifo_empty),
    .ptr_i     (prio_q),
    .en_i      (rd_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = gnt_vld ? gnt_idx + SRC_WIDTH'(1) : prio_q;
    case (state_q)
      IDLE:    if (any_req) state_d = out_almost_full ? HOLD : ACTIVE;
      ACTIVE: begin
        if (out_almost_full) state_d = HOLD;
        else if (!any_req)   state_d = IDLE;
      end
      HOLD:    if (!out_almost_full) state_d = any_req ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO buff_out is valid the cycle after the pop, selected by the registered grant.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gidx_q == i[SRC_WIDTH-1:0]) word_sel = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state_q     <= IDLE;
      prio_q      <= '0;
      pend_q      <= 1'b0;
      gidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      pend_q      <= gnt_vld;
      out_valid_q <= pend_q;
      if (gnt_vld) begin
        gidx_q <= gnt_idx;
        cnt_q  <= cnt_q + COUNT_WIDTH'(1);
      end
      if (pend_q) begin
        out_data_q <= word_sel;
        out_src_q  <= gidx_q;
      end
    end
  end

  assign fifo_read = gnt;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign pop_count = cnt_q;
  assign idle      = (state_q == IDLE) && !pend_q && !out_valid_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter with a queue-based FIFO bank model and
// per-cycle expectation strings (one character per cycle).
module tb_fifo_pop_arbiter;

  localparam int NF = 4;
  localparam int DW = 4;
  localparam int SW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_L;
  logic [NF-1:0]        fifo_empty;
  logic [NF*DW-1:0]     fifo_data;
  logic                 out_almost_full;
  logic [NF-1:0]        fifo_read;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_src;
  logic                 idle;
  logic [CW-1:0]        pop_count;

  fifo_pop_arbiter #(
    .NUM_FIFOS   (NF),
    .DATA_WIDTH  (DW),
    .SRC_WIDTH   (SW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .fifo_read       (fifo_read),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_src         (out_src),
    .idle            (idle),
    .pop_count       (pop_count)
  );

  logic [DW-1:0] fq [NF][$];
  logic [DW-1:0] dout [NF];

  logic [NF-1:0] s_rd;
  logic          s_ov;
  logic [DW-1:0] s_od;
  logic [SW-1:0] s_os;
  logic          s_idle;
  logic [CW-1:0] s_pc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - 8'h30);
    return 4'(ch - 8'h37);
  endfunction

  task automatic refresh();
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i]          = (fq[i].size() == 0);
      fifo_data[i*DW +: DW] = dout[i];
    end
  endtask

  task automatic load(input int f, input logic [DW-1:0] v);
    fq[f].push_back(v);
  endtask

  // Sample outputs mid-cycle, then apply pops just after the edge like a real FIFO.
  task automatic run_cycle();
    @(negedge clk);
    s_rd   = fifo_read;
    s_ov   = out_valid;
    s_od   = out_data;
    s_os   = out_src;
    s_idle = idle;
    s_pc   = pop_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++) begin
      if (s_rd[i] === 1'b1) begin
        chk($sformatf("pop_nonempty_f%0d", i), 32'(fq[i].size() != 0), 32'd1);
        if (fq[i].size() != 0) dout[i] = fq[i].pop_front();
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    reset_L = 1'b1;
    run_cycle();
    run_cycle();
    reset_L = 1'b0;
  endtask

  task automatic run_seq(input string tag, input string rst_t, input string af_t,
                         input string rd_t, input string ov_t,
                         input string src_t, input string dat_t);
    int k = 0;
    for (int c = 0; c < rd_t.len(); c++) begin
      reset_L         = (rst_t[c] == "1");
      out_almost_full = (af_t[c] == "1");
      run_cycle();
      chk($sformatf("%s_rd_c%0d", tag, c + 1), 32'(s_rd), 32'(hexval(rd_t[c])));
      chk($sformatf("%s_ov_c%0d", tag, c + 1), 32'(s_ov), 32'(ov_t[c] == "1"));
      if (ov_t[c] == "1") begin
        chk($sformatf("%s_dat_c%0d", tag, c + 1), 32'(s_od), 32'(hexval(dat_t[k])));
        chk($sformatf("%s_src_c%0d", tag, c + 1), 32'(s_os), 32'(hexval(src_t[k])));
        k++;
      end
    end
    out_almost_full = 1'b0;
  endtask

  initial begin
    reset_L         = 1'b1;
    out_almost_full = 1'b0;
    for (int i = 0; i < NF; i++) dout[i] = '0;
    refresh();
    @(posedge clk);
    #1;

    // Reset while every FIFO holds data
    for (int i = 0; i < NF; i++) load(i, 4'(i + 1));
    refresh();
    do_reset();
    chk("rst_rd", 32'(s_rd), 32'd0);
    chk("rst_ov", 32'(s_ov), 32'd0);
    chk("rst_dat", 32'(s_od), 32'd0);
    chk("rst_src", 32'(s_os), 32'd0);
    chk("rst_pc", 32'(s_pc), 32'd0);
    chk("rst_idle", 32'(s_idle), 32'd1);
    for (int i = 0; i < NF; i++) fq[i].delete();
    refresh();

    // Single FIFO, three words back-to-back
    load(2, 4'hA); load(2, 4'hB); load(2, 4'hC);
    refresh();
    run_seq("one", "0000000", "0000000", "0444000", "0001110", "222", "ABC");
    chk("one_pc", 32'(s_pc), 32'd3);
    chk("one_idle", 32'(s_idle), 32'd1);

    // Round-robin over all four FIFOs
    do_reset();
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 2; j++) load(i, 4'(i * 2 + j));
    refresh();
    run_seq("rr", "000000000000", "000000000000", "012481248000", "000111111110",
            "01230123", "02461357");
    chk("rr_pc", 32'(s_pc), 32'd8);
    chk("rr_idle", 32'(s_idle), 32'd1);

    // Five-cycle stall in the middle of a burst
    do_reset();
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 2; j++) load(i, 4'(8 + i * 2 + j));
    refresh();
    run_seq("stall", "000000000000000000", "000111110000000000", "012000000481248000",
            "000110000001111110", "01230123", "8ACE9BDF");
    chk("stall_pc", 32'(s_pc), 32'd8);

    // Reset right after a pop drops the word and restarts the pointer
    do_reset();
    load(1, 4'h5);
    refresh();
    run_seq("rstA", "001", "000", "020", "000", "", "");
    load(0, 4'h3); load(3, 4'hD);
    refresh();
    run_seq("rstB", "000000", "000000", "018000", "000110", "03", "3D");
    chk("rstB_pc", 32'(s_pc), 32'd2);
    chk("rstB_idle", 32'(s_idle), 32'd1);

    // Stall release coinciding with all-empty goes straight to idle
    do_reset();
    load(2, 4'h7);
    refresh();
    run_seq("hold", "00000", "00100", "04000", "00010", "2", "7");
    chk("hold_idle", 32'(s_idle), 32'd1);
    chk("hold_pc", 32'(s_pc), 32'd1);

    // Pop counter wrap after 17 pops
    do_reset();
    for (int j = 0; j < 17; j++) load(0, 4'(j));
    refresh();
    run_cycle();
    chk("wrap_rd_first", 32'(s_rd), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      run_cycle();
      chk($sformatf("wrap_rd_%0d", k), 32'(s_rd), 32'd1);
      if (k == 17) chk("wrap_pc16", 32'(s_pc), 32'd0);
    end
    run_cycle();
    chk("wrap_rd_last", 32'(s_rd), 32'd0);
    chk("wrap_pc17", 32'(s_pc), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Consumer-side controller for a bank of `fifo` instances: watches each FIFO's empty flag, issues one-hot `read` pulses under round-robin arbitration, and forwards the popped word downstream with its source index. It is the reader end of the FIFO push/pop interface and sits between the per-class FIFOs and the next pipeline stage (demux or output register). Downstream backpressure uses an almost-full style stall input.

## Interface
- `NUM_FIFOS`, 4, number of FIFOs drained (power of two, ≥2)
- `DATA_WIDTH`, 4, word width; equals the FIFO `buff_out` width
- `SRC_WIDTH`, 2, log2(NUM_FIFOS)
- `COUNT_WIDTH`, 4, width of the pop counter
- `clk`  in  1  single clock, all logic on rising edge
- `reset_L`  in  1  one clock; reset is synchronous and active-high
- `fifo_empty`  in  NUM_FIFOS  per-FIFO empty flag, bit i = FIFO i
- `fifo_data`  in  NUM_FIFOS*DATA_WIDTH  concatenated FIFO `buff_out`; FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `out_almost_full`  in  1  downstream stall; no new pop issued while high
- `fifo_read`  out  NUM_FIFOS  one-hot or zero pop strobe, bit i to FIFO i `read`
- `out_valid`  out  1  `out_data`/`out_src` hold a popped word this cycle
- `out_data`  out  DATA_WIDTH  popped word
- `out_src`  out  SRC_WIDTH  index of FIFO the word came from
- `idle`  out  1  state IDLE and no pop in flight
- `pop_count`  out  COUNT_WIDTH  total pops issued, wraps modulo 2^COUNT_WIDTH

## Operation
- FSM states: IDLE, ACTIVE, HOLD.
  - IDLE: all `fifo_empty` high. → ACTIVE when any bit low and `out_almost_full` low; → HOLD when any bit low and `out_almost_full` high.
  - ACTIVE: one pop per cycle. → HOLD when `out_almost_full` high; → IDLE when all empty.
  - HOLD: `fifo_read` = 0. → ACTIVE when `out_almost_full` low and any non-empty; → IDLE when stall low and all empty.
- `fifo_read` is combinational from state, `fifo_empty`, `out_almost_full`, and the priority pointer. Never asserted for an empty FIFO or while `out_almost_full` is high, including on the transition cycle.
- Round-robin: search starts at `prio_ptr` and picks the first non-empty index, wrapping modulo NUM_FIFOS. After a grant to i, `prio_ptr` ← (i+1) mod NUM_FIFOS. `prio_ptr` is unchanged when no grant.
- Grant index and a pending bit are registered on the pop cycle. One cycle later the word is taken from `fifo_data` at the registered index and registered into `out_data`/`out_src`, with `out_valid` = 1.
- In-flight words are never dropped by `out_almost_full`. Downstream threshold margin covers 2 words.
- `pop_count` increments by 1 per cycle with any `fifo_read` bit set; 2^COUNT_WIDTH−1 → 0.
- `idle` = (state == IDLE) & !pending & !out_valid.

## Timing
- Reset, sampled on `clk`, state → IDLE with:
  - `prio_ptr` = 0, pending = 0
  - `fifo_read` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `pop_count` = 0, `idle` = 1
- Reset mid-operation discards any pending word. `out_valid` is 0 the cycle after reset is sampled.
- Latency: `fifo_read[i]` high in cycle N → `fifo_data` slice i valid in N+1 → `out_valid`, `out_data`, `out_src` = i in N+2.
- Throughput: 1 word/cycle while any FIFO non-empty and no stall.
- FIFO with one entry: popped in N, `fifo_empty` high in N+1, no second read. Arbiter moves on in N+1.
- `out_almost_full` rising in cycle N: no read in N. Words popped in N−1 and N−2 still emerge.
- Simultaneous stall deassert and all-empty: → IDLE, no read.

## Structure
- Package `fifo_pop_pkg`: state enum localparams (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2), default widths.
- Sub-module `rr_arbiter`:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational.
- Top holds FSM, pipeline registers, counter.

## Test plan
- Reset with all FIFOs holding data → `fifo_read`=0, `out_valid`=0, `pop_count`=0, `idle`=1 the cycle after reset is sampled.
- Only FIFO 2 non-empty with 3 words (0xA, 0xB, 0xC), no stall:
  - `fifo_read`=4'b0100 for 3 consecutive cycles
  - `out_data` = A, B, C on cycles N+2..N+4, `out_src`=2
  - `pop_count`=3
- All 4 FIFOs with 2 words each → grant order 0,1,2,3,0,1,2,3; 8 `out_valid` cycles back-to-back; `pop_count`=8; then IDLE.
- `out_almost_full` high for 5 cycles mid-burst → no `fifo_read` during stall; the 2 in-flight words still appear; popping resumes from the next round-robin index with no loss or duplication.
- Reset asserted the cycle after a pop → popped word never appears on `out_valid`; `prio_ptr` restarts at 0.
- 17 pops with COUNT_WIDTH=4 → `pop_count` wraps to 1.
